stream_pkt_fifo: RTL

Store-and-forward packet FIFO placed directly downstream of the header-insertion stage. Accepts a keep/last byte stream, buffers whole packets, and releases a packet to the consumer only after its last beat has been written. Each released packet carries its total byte length, so downstream framing and DMA logic gets a length before the first beat.

---
 rtl/stream_pkt_fifo_pkg.sv | 16 +
 rtl/stream_pkt_fifo_if.sv | 32 +++
 rtl/stream_pkt_fifo_sync_fifo.sv | 41 ++++
 rtl/stream_pkt_fifo.sv | 78 +++++++
 4 files changed

// File: rtl/stream_pkt_fifo_pkg.sv
// stream_pkt_fifo_pkg: shared stream widths, length sizing and keep popcount.
package stream_pkt_fifo_pkg;
   localparam int DEF_DATA_WD      = 32;
   localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;
   localparam int DEF_DEPTH        = 16;
   localparam int CNT_WD           = $clog2(DEF_DATA_BYTE_WD) + 1;

   function automatic int len_wd(input int depth, input int bytes);
      return $clog2(depth * bytes) + 1;
   endfunction

   function automatic logic [CNT_WD-1:0] popcount(input logic [DEF_DATA_BYTE_WD-1:0] keep);
      popcount = '0;
      for (int i = 0; i < DEF_DATA_BYTE_WD; i++) popcount += CNT_WD'(keep[i]);
   endfunction
endpackage

// File: rtl/stream_pkt_fifo_if.sv
// stream_pkt_fifo_if: keep/last input stream and length-tagged output stream.
interface stream_pkt_fifo_if
   import stream_pkt_fifo_pkg::*;
#(
   parameter int DATA_WD = DEF_DATA_WD,
   parameter int DEPTH   = DEF_DEPTH
);
   localparam int DATA_BYTE_WD = DATA_WD / 8;
   localparam int LEN_WD       = len_wd(DEPTH, DATA_BYTE_WD);

   logic                    valid_in;
   logic [DATA_BYTE_WD-1:0] keep_in;
   logic [DATA_WD-1:0]      data_in;
   logic                    last_in;
   logic                    ready_in;
   logic                    valid_out;
   logic [DATA_BYTE_WD-1:0] keep_out;
   logic [DATA_WD-1:0]      data_out;
   logic                    last_out;
   logic [LEN_WD-1:0]       len_out;
   logic                    ready_out;

   modport master (
      output valid_in, keep_in, data_in, last_in, ready_out,
      input  ready_in, valid_out, keep_out, data_out, last_out, len_out
   );

   modport slave (
      input  valid_in, keep_in, data_in, last_in, ready_out,
      output ready_in, valid_out, keep_out, data_out, last_out, len_out
   );
endinterface

// File: rtl/stream_pkt_fifo_sync_fifo.sv
// sync_fifo: wrap-bit pointer FIFO with registered pointers and asynchronous read.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(rd_en);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/stream_pkt_fifo.sv
// stream_pkt_fifo: store-and-forward packet FIFO that releases whole packets
// tagged with their total byte length.
module stream_pkt_fifo
   import stream_pkt_fifo_pkg::*;
#(
   parameter int DATA_WD = DEF_DATA_WD,
   parameter int DEPTH   = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   stream_pkt_fifo_if.slave         s,
   output logic [$clog2(DEPTH):0]   pkt_cnt,
   output logic                     err_oversize
);
   localparam int DATA_BYTE_WD = DATA_WD / 8;
   localparam int ADDR_WD      = $clog2(DEPTH);
   localparam int PCW          = ADDR_WD + 1;
   localparam int LEN_WD       = len_wd(DEPTH, DATA_BYTE_WD);
   localparam int DW           = DATA_WD + DATA_BYTE_WD + 1;

   logic              fire_in, fire_out, commit, pop;
   logic              full, len_full;
   logic [DW-1:0]     head;
   logic [LEN_WD-1:0] len_head, acc_next, acc_q, acc_d;
   logic [PCW-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic              err_q, err_d;

   always_comb begin
      fire_in   = s.valid_in & s.ready_in;
      fire_out  = s.valid_out & s.ready_out;
      commit    = fire_in & s.last_in;
      pop       = fire_out & head[DW-1];
      acc_next  = acc_q + LEN_WD'(popcount(s.keep_in));
      acc_d     = fire_in ? (s.last_in ? '0 : acc_next) : acc_q;
      pkt_cnt_d = pkt_cnt_q + PCW'(commit) - PCW'(pop);
      // A full buffer with no complete packet can never drain: lock up until reset.
      err_d     = err_q | (full & (pkt_cnt_q == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         pkt_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_q     <= err_d;
      end
   end

   sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_data_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fire_in),
      .wr_data ({s.last_in, s.keep_in, s.data_in}),
      .rd_en   (fire_out),
      .rd_data (head),
      .full    (full)
   );

   sync_fifo #(.WIDTH(LEN_WD), .DEPTH(DEPTH)) u_len_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (commit),
      .wr_data (acc_next),
      .rd_en   (pop),
      .rd_data (len_head),
      .full    (len_full)
   );

   assign s.ready_in  = !full & !len_full & !err_q;
   assign s.valid_out = pkt_cnt_q != '0;
   assign {s.last_out, s.keep_out, s.data_out} = s.valid_out ? head : '0;
   assign s.len_out   = s.valid_out ? len_head : '0;
   assign pkt_cnt     = pkt_cnt_q;
   assign err_oversize = err_q;
endmodule
